oled_i2c_master: RTL and testbench

//   Byte-level I2C master that drives the SSD1306 OLED bus. It sits directly downstream of the OLED

---
 rtl/oled_i2c_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_oled_i2c_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_i2c_master.sv
// oled_i2c_master: byte-level, write-only I2C master for the SSD1306 OLED bus.
// Takes one byte per valid/ready handshake. Each byte is framed with START,
// repeated START or STOP, then shifted out MSB-first. scl is push-pull and sda
// is open-drain.
// Optional feature: define OLED_I2C_ACK_CHECK_EN to sample the ACK slot. A NACK
// then sets sticky nack and ends the transfer with STOP.
module oled_i2c_master #(
    parameter int unsigned CLK_HZ = 12_000_000,
    parameter int unsigned I2C_HZ = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned QDIV_RAW = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int unsigned QW       = $clog2(QDIV + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BIT    = 3'd2,
        S_ACK    = 3'd3,
        S_HOLD   = 3'd4,
        S_RSTART = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t          r_state, w_state_n;
    logic [1:0]      r_q, w_q_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_stop, w_stop_n;
    logic [QW-1:0]   r_qcnt, w_qcnt_n;
    logic            r_scl, w_scl_n;
    logic            r_sda_lo, w_sda_lo_n;
    logic            r_ready, w_ready_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic            w_accept;
    logic            w_run;
    logic            w_tick;
    logic            w_ack_bad;

`ifdef OLED_I2C_ACK_CHECK_EN
    logic            w_sda_in;
    logic            r_ack_bad, w_ack_bad_n;
    logic            r_nack, w_nack_n;

    assign w_sda_in  = sda;
    assign w_ack_bad = r_ack_bad;
    assign nack      = r_nack;
`else
    assign w_ack_bad = 1'b0;
    assign nack      = 1'b0;
`endif

    assign w_accept  = cmd_valid && r_ready;
    assign w_run     = (r_state != S_IDLE) && (r_state != S_HOLD);
    assign w_tick    = (r_qcnt == QW'(QDIV - 1));

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign scl       = r_scl;
    assign sda       = r_sda_lo ? 1'b0 : 1'bz;

    // Next-state logic; bus pins and status outputs are derived from the next state
    always_comb begin
        w_state_n  = r_state;
        w_q_n      = r_q;
        w_bit_n    = r_bit;
        w_data_n   = r_data;
        w_stop_n   = r_stop;
        w_qcnt_n   = r_qcnt;
        w_done_n   = 1'b0;
        w_scl_n    = 1'b1;
        w_sda_lo_n = 1'b0;
        w_ready_n  = 1'b0;
        w_busy_n   = 1'b1;
`ifdef OLED_I2C_ACK_CHECK_EN
        w_ack_bad_n = r_ack_bad;
        w_nack_n    = r_nack;
`endif

        if (w_run) begin
            w_qcnt_n = w_tick ? '0 : r_qcnt + QW'(1);
        end

        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_accept) begin
                    w_data_n = cmd_data;
                    w_stop_n = cmd_stop;
                    w_q_n    = 2'd0;
                    w_bit_n  = 3'd7;
                    w_qcnt_n = '0;
`ifdef OLED_I2C_ACK_CHECK_EN
                    w_ack_bad_n = 1'b0;
                    if (cmd_start) begin
                        w_nack_n = 1'b0;
                    end
`endif
                    if (r_state == S_IDLE) begin
                        w_state_n = S_START;
                    end else if (cmd_start) begin
                        w_state_n = S_RSTART;
                    end else begin
                        w_state_n = S_BIT;
                    end
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_q == 2'd1) begin
                        w_state_n = S_BIT;
                        w_q_n     = 2'd0;
                        w_bit_n   = 3'd7;
                    end else begin
                        w_q_n = r_q + 2'd1;
                    end
                end
            end
            S_RSTART: begin
                if (w_tick) begin
                    if (r_q == 2'd1) begin
                        w_state_n = S_START;
                        w_q_n     = 2'd0;
                    end else begin
                        w_q_n = r_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (w_tick) begin
                    if (r_q == 2'd3) begin
                        w_q_n = 2'd0;
                        if (r_bit == 3'd0) begin
                            w_state_n = S_ACK;
                        end else begin
                            w_bit_n = r_bit - 3'd1;
                        end
                    end else begin
                        w_q_n = r_q + 2'd1;
                    end
                end
            end
            S_ACK: begin
                if (w_tick) begin
`ifdef OLED_I2C_ACK_CHECK_EN
                    if ((r_q == 2'd2) && w_sda_in) begin
                        w_ack_bad_n = 1'b1;
                        w_nack_n    = 1'b1;
                    end
`endif
                    if (r_q == 2'd3) begin
                        w_q_n = 2'd0;
                        if (r_stop || w_ack_bad) begin
                            w_state_n = S_STOP;
                        end else begin
                            w_state_n = S_HOLD;
                            w_done_n  = 1'b1;
                        end
                    end else begin
                        w_q_n = r_q + 2'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_q == 2'd3) begin
                        w_state_n = S_IDLE;
                        w_q_n     = 2'd0;
                        w_done_n  = 1'b1;
                    end else begin
                        w_q_n = r_q + 2'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_q_n     = 2'd0;
            end
        endcase

        case (w_state_n)
            S_IDLE: begin
                w_ready_n = 1'b1;
                w_busy_n  = 1'b0;
            end
            S_HOLD: begin
                w_scl_n    = 1'b0;
                w_sda_lo_n = 1'b1;
                w_ready_n  = 1'b1;
                w_busy_n   = 1'b0;
            end
            S_START: begin
                w_sda_lo_n = (w_q_n == 2'd1);
            end
            S_RSTART: begin
                w_scl_n = (w_q_n == 2'd1);
            end
            S_BIT: begin
                w_scl_n    = w_q_n[1];
                w_sda_lo_n = ~w_data_n[w_bit_n];
            end
            S_ACK: begin
                w_scl_n = w_q_n[1];
            end
            S_STOP: begin
                w_scl_n    = (w_q_n != 2'd0);
                w_sda_lo_n = (w_q_n <= 2'd1);
            end
            default: begin
                w_ready_n = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_q      <= 2'd0;
            r_bit    <= 3'd7;
            r_data   <= 8'd0;
            r_stop   <= 1'b0;
            r_qcnt   <= '0;
            r_scl    <= 1'b1;
            r_sda_lo <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_q      <= w_q_n;
            r_bit    <= w_bit_n;
            r_data   <= w_data_n;
            r_stop   <= w_stop_n;
            r_qcnt   <= w_qcnt_n;
            r_scl    <= w_scl_n;
            r_sda_lo <= w_sda_lo_n;
            r_ready  <= w_ready_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
        end
    end

`ifdef OLED_I2C_ACK_CHECK_EN
    // Per-byte ACK result and sticky nack flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_bad <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_ack_bad <= w_ack_bad_n;
            r_nack    <= w_nack_n;
        end
    end
`endif

endmodule

// File: tb/tb_oled_i2c_master.sv
// Bench for oled_i2c_master at QDIV=1. A bus monitor turns scl/sda into a token
// string ('S' start, 'P' stop, '0'/'1' bits incl. ACK slot). A slave model ACKs
// or NACKs according to a plan. A transaction-level model predicts tokens, done
// timing and the nack flag.
`timescale 1ns/1ps
module tb_oled_i2c_master;
    localparam int unsigned CLK_HZ = 400_000;
    localparam int unsigned I2C_HZ = 100_000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    wire        cmd_ready, busy, done, nack, scl;
    wire        sda;
    logic       slv_drive = 1'b0;

    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    oled_i2c_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .busy(busy), .done(done), .nack(nack), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        bit         s;
        bit         p;
        bit         nk;
    } cmd_t;

    cmd_t  seq[$];
    bit    nack_plan[$];
    int    done_q[$];
    int    stamp_q[$];
    string mon_str = "";
    string exp_str = "";
    string exp_done = "";
    string act_done = "";
    bit    m_owned = 0;
    bit    m_nack = 0;

    logic  prev_s = 1'b1, prev_d = 1'b1, pending = 1'b0, pbit = 1'b0, slv_in_ack = 1'b0;
    int    slv_cnt = 0;

    // Bus monitor plus ACKing slave, sampled mid-cycle
    always @(negedge clk) begin : mon
        logic s, d;
        s = scl;
        d = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (prev_s && s && prev_d && !d) begin
            mon_str = {mon_str, "S"};
            pending = 0; slv_cnt = 0; slv_in_ack = 0; slv_drive = 0;
        end else if (prev_s && s && !prev_d && d) begin
            mon_str = {mon_str, "P"};
            pending = 0; slv_cnt = 0; slv_in_ack = 0; slv_drive = 0;
        end
        if (!prev_s && s) begin
            pending = 1;
            pbit = d;
            if (!slv_in_ack) slv_cnt++;
        end
        if (prev_s && !s) begin
            if (pending) begin
                if (pbit) mon_str = {mon_str, "1"};
                else      mon_str = {mon_str, "0"};
            end
            pending = 0;
            if (slv_in_ack) begin
                slv_in_ack = 0; slv_drive = 0; slv_cnt = 0;
            end else if (slv_cnt == 8) begin
                slv_in_ack = 1;
                slv_drive = (nack_plan.size() > 0) ? !nack_plan.pop_front() : 1'b1;
            end
        end
        if (done === 1'b1) done_q.push_back(cyc);
        prev_s = s;
        prev_d = d;
    end

    // Drive the queued commands, build expected tokens/done times from the transaction model
    task automatic run_seq(output bit ok);
        int quarters[$];
        int n;
        ok = 1;
        exp_str = ""; mon_str = "";
        done_q.delete(); stamp_q.delete(); nack_plan.delete();
        foreach (seq[i]) nack_plan.push_back(seq[i].nk);
        foreach (seq[i]) begin
            int  q;
            bit  ends;
            q = 36;
            if (!m_owned || seq[i].s) begin
                exp_str = {exp_str, "S"};
                q += m_owned ? 4 : 2;
            end
            if (seq[i].s) m_nack = 0;
            for (int b = 7; b >= 0; b--) begin
                if (seq[i].d[b]) exp_str = {exp_str, "1"};
                else             exp_str = {exp_str, "0"};
            end
            if (seq[i].nk) exp_str = {exp_str, "1"};
            else           exp_str = {exp_str, "0"};
            ends = seq[i].p;
`ifdef OLED_I2C_ACK_CHECK_EN
            if (seq[i].nk) begin
                m_nack = 1;
                ends = 1;
            end
`endif
            if (ends) begin
                exp_str = {exp_str, "P"};
                q += 4;
                m_owned = 0;
            end else begin
                m_owned = 1;
            end
            quarters.push_back(q);

            cmd_valid = 1'b1;
            cmd_data  = seq[i].d;
            cmd_start = seq[i].s;
            cmd_stop  = seq[i].p;
            n = 0;
            while (cmd_ready !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (n >= 400) begin
                cmd_valid = 1'b0;
                ok = 0;
                return;
            end
            @(negedge clk);
            stamp_q.push_back(cyc);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (done_q.size() < seq.size() && n < 200 * seq.size()) begin
            @(negedge clk);
            n++;
        end
        if (done_q.size() < seq.size()) ok = 0;
        repeat (3) @(negedge clk);
        exp_done = ""; act_done = "";
        foreach (stamp_q[i]) exp_done = {exp_done, $sformatf("%0d ", stamp_q[i] + quarters[i])};
        foreach (done_q[i])  act_done = {act_done, $sformatf("%0d ", done_q[i])};
    endtask

    function automatic cmd_t mk(input logic [7:0] d, input bit s, input bit p, input bit nk);
        cmd_t c;
        c.d = d; c.s = s; c.p = p; c.nk = nk;
        return c;
    endfunction

    task automatic test_reset();
        checks++; if (scl !== 1'b1)       begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
        checks++; if (sda !== 1'b1)       begin errors++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (nack !== 1'b0)      begin errors++; $display("FAIL reset_nack: got %b want 0", nack); end
    endtask

    task automatic test_single();
        bit ok;
        seq.delete(); seq.push_back(mk(8'h78, 1, 1, 0));
        run_seq(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: transfer did not complete, want done"); end
        checks++; if (mon_str != "S011110000P") begin errors++; $display("FAIL single_bus: got %s want S011110000P", mon_str); end
        checks++; if (act_done != $sformatf("%0d ", stamp_q[0] + 42)) begin errors++; $display("FAIL single_latency: done at %s want %0d", act_done, stamp_q[0] + 42); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL single_nack: got %b want 0", nack); end
        checks++; if ({busy, cmd_ready, scl, sda} !== 4'b0111) begin errors++; $display("FAIL single_idle: busy/ready/scl/sda=%b want 0111", {busy, cmd_ready, scl, sda}); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        seq.delete(); seq.push_back(mk(8'h78, 1, 0, 0));
        run_seq(ok);
        checks++; if (!ok || mon_str != "S011110000") begin errors++; $display("FAIL b2b_first: got %s want S011110000", mon_str); end
        checks++; if ({busy, cmd_ready, scl, sda} !== 4'b0100) begin errors++; $display("FAIL b2b_hold: busy/ready/scl/sda=%b want 0100", {busy, cmd_ready, scl, sda}); end
        seq.delete(); seq.push_back(mk(8'h00, 0, 0, 0)); seq.push_back(mk(8'hAF, 0, 1, 0));
        run_seq(ok);
        checks++; if (!ok || mon_str != "000000000101011110P") begin errors++; $display("FAIL b2b_rest: got %s want 000000000101011110P", mon_str); end
        checks++; if (act_done != exp_done) begin errors++; $display("FAIL b2b_done: got %s want %s", act_done, exp_done); end
        checks++; if (done_q.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_q.size()); end
    endtask

    task automatic test_repeated_start();
        bit ok;
        seq.delete(); seq.push_back(mk(8'h78, 1, 0, 0)); seq.push_back(mk(8'h3C, 1, 1, 0));
        run_seq(ok);
        checks++; if (!ok || mon_str != "S011110000S001111000P") begin errors++; $display("FAIL rstart_bus: got %s want S011110000S001111000P", mon_str); end
        checks++; if (act_done != $sformatf("%0d %0d ", stamp_q[0] + 38, stamp_q[1] + 44)) begin errors++; $display("FAIL rstart_done: got %s want %s", act_done, exp_done); end
        checks++; if ({busy, cmd_ready, scl, sda} !== 4'b0111) begin errors++; $display("FAIL rstart_idle: busy/ready/scl/sda=%b want 0111", {busy, cmd_ready, scl, sda}); end
    endtask

    task automatic test_nack();
        bit ok;
        seq.delete(); seq.push_back(mk(8'h78, 1, 0, 1));
        run_seq(ok);
`ifdef OLED_I2C_ACK_CHECK_EN
        checks++; if (!ok || mon_str != "S011110001P") begin errors++; $display("FAIL nack_bus: got %s want S011110001P", mon_str); end
        checks++; if (nack !== 1'b1) begin errors++; $display("FAIL nack_set: got %b want 1", nack); end
        checks++; if (act_done != $sformatf("%0d ", stamp_q[0] + 42)) begin errors++; $display("FAIL nack_done: got %s want %0d", act_done, stamp_q[0] + 42); end
        checks++; if ({busy, cmd_ready, scl, sda} !== 4'b0111) begin errors++; $display("FAIL nack_idle: busy/ready/scl/sda=%b want 0111", {busy, cmd_ready, scl, sda}); end
        seq.delete(); seq.push_back(mk(8'h3C, 1, 1, 0));
        run_seq(ok);
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL nack_clear: got %b want 0", nack); end
`else
        checks++; if (!ok || mon_str != "S011110001") begin errors++; $display("FAIL nack_bus: got %s want S011110001", mon_str); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL nack_tied: got %b want 0", nack); end
        checks++; if (act_done != $sformatf("%0d ", stamp_q[0] + 38)) begin errors++; $display("FAIL nack_done: got %s want %0d", act_done, stamp_q[0] + 38); end
        checks++; if ({busy, cmd_ready, scl, sda} !== 4'b0100) begin errors++; $display("FAIL nack_hold: busy/ready/scl/sda=%b want 0100", {busy, cmd_ready, scl, sda}); end
        seq.delete(); seq.push_back(mk(8'h00, 0, 1, 0));
        run_seq(ok);
`endif
        checks++; if (!ok || mon_str != exp_str) begin errors++; $display("FAIL nack_follow: got %s want %s", mon_str, exp_str); end
    endtask

    task automatic test_reset_abort();
        bit    ok;
        string exp_abort;
        logic [7:0] d;
        d = 8'($urandom);
        nack_plan.delete(); mon_str = "";
        cmd_valid = 1'b1; cmd_data = d; cmd_start = 1'b1; cmd_stop = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (14) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({scl, sda, busy, cmd_ready, done} !== 5'b11010) begin errors++; $display("FAIL abort_reset: scl/sda/busy/ready/done=%b want 11010", {scl, sda, busy, cmd_ready, done}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_owned = 0; m_nack = 0;
        exp_abort = "S";
        for (int b = 7; b >= 5; b--) begin
            if (d[b]) exp_abort = {exp_abort, "1"};
            else      exp_abort = {exp_abort, "0"};
        end
        checks++; if (mon_str != exp_abort) begin errors++; $display("FAIL abort_no_stop: got %s want %s", mon_str, exp_abort); end
        @(negedge clk);
        seq.delete(); seq.push_back(mk(8'h5A, 0, 1, 0));
        run_seq(ok);
        checks++; if (!ok || mon_str != "S010110100P") begin errors++; $display("FAIL abort_restart: got %s want S010110100P", mon_str); end
        checks++; if (act_done != exp_done) begin errors++; $display("FAIL abort_done: got %s want %s", act_done, exp_done); end
    endtask

    task automatic test_random();
        bit ok;
        for (int t = 0; t < 20; t++) begin
            int nb;
            nb = $urandom_range(1, 4);
            seq.delete();
            for (int k = 0; k < nb; k++)
                seq.push_back(mk(8'($urandom), 1'($urandom_range(0, 1)),
                                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0)));
            run_seq(ok);
            checks++; if (!ok || mon_str != exp_str) begin errors++; $display("FAIL rand%0d_bus: got %s want %s", t, mon_str, exp_str); end
            checks++; if (act_done != exp_done) begin errors++; $display("FAIL rand%0d_done: got %s want %s", t, act_done, exp_done); end
            checks++; if (nack !== m_nack) begin errors++; $display("FAIL rand%0d_nack: got %b want %b", t, nack, m_nack); end
            checks++; if ({busy, cmd_ready, scl} !== {2'b01, !m_owned}) begin errors++; $display("FAIL rand%0d_state: busy/ready/scl=%b want %b", t, {busy, cmd_ready, scl}, {2'b01, !m_owned}); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_repeated_start();
        test_nack();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end
endmodule
